// File: rtl/seq53_run_ctrl_pkg.sv
// ============================================================================
// seq53_run_ctrl_pkg : shared state encoding, default constants and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package seq53_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LATCH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned C_STEP_W      = 4;
  localparam logic [15:0] C_DEF_PATTERN = 16'h2DE4;
  localparam logic [7:0]  C_DEF_EXPECT  = 8'h00;

  // Pair i sits at bits [2i+1:2i]: bit 1 drives x1, bit 0 drives x2.
  function automatic logic [1:0] pattern_pair(input logic [31:0]         pat,
                                              input logic [C_STEP_W-1:0] idx);
    logic [31:0] sh;
    sh = pat >> {idx, 1'b0};
    return sh[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq53_settle_cnt.sv
// ============================================================================
// seq53_settle_cnt : settle timer, flags the last of DIV cycles after a clear
// Rev 1.0
// ============================================================================
`default_nettype none

module seq53_settle_cnt #(
  parameter int DIV = 2
) (
  input  logic cp,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int            CW       = $clog2(DIV) + 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule

`default_nettype wire

// File: rtl/seq53_run_ctrl.sv
// ============================================================================
// seq53_run_ctrl : steps the example 5.3 circuit through N input pairs,
//                  records z per step and checks the history against EXPECT
// Rev 1.0
// ============================================================================
`default_nettype none

module seq53_run_ctrl
  import seq53_run_ctrl_pkg::*;
#(
  parameter int             N       = 8,
  parameter int             DIV     = 2,
  parameter logic [2*N-1:0] PATTERN = C_DEF_PATTERN,
  parameter logic           INIT_Y  = 1'b0,
  parameter logic [N-1:0]   EXPECT  = C_DEF_EXPECT
) (
  input  logic                cp,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                ny_in,
  input  logic                z_in,
  output logic                x1,
  output logic                x2,
  output logic                y,
  output logic [C_STEP_W-1:0] step,
  output logic [N-1:0]        z_hist,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  localparam logic [31:0]         PAT32     = 32'(PATTERN);
  localparam logic [C_STEP_W-1:0] LAST_STEP = C_STEP_W'(N - 1);

  state_t              state_q, state_d;
  logic                x1_q, x1_d;
  logic                x2_q, x2_d;
  logic                y_q, y_d;
  logic [C_STEP_W-1:0] step_q, step_d;
  logic [N-1:0]        z_hist_q, z_hist_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_last;
  logic [N-1:0]        hist_nxt;
  logic [1:0]          pair;

  seq53_settle_cnt #(
    .DIV (DIV)
  ) u_settle_cnt (
    .cp   (cp),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  // History as it will look once the current step's z is folded in.
  always_comb begin
    hist_nxt = z_hist_q;
    for (int i = 0; i < N; i++) begin
      if (step_q == C_STEP_W'(i)) begin
        hist_nxt[i] = z_in;
      end
    end
  end

  assign pair = pattern_pair(PAT32, step_q);

  always_comb begin
    state_d  = state_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    y_d      = y_q;
    step_d   = step_q;
    z_hist_d = z_hist_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      x1_d    = 1'b0;
      x2_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d  = ST_APPLY;
            y_d      = INIT_Y;
            step_d   = '0;
            z_hist_d = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            pass_d   = 1'b0;
          end
        end
        ST_APPLY: begin
          x1_d    = pair[1];
          x2_d    = pair[0];
          cnt_clr = 1'b1;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          y_d      = ny_in;
          z_hist_d = hist_nxt;
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (hist_nxt == EXPECT);
          end else begin
            step_d  = step_q + C_STEP_W'(1);
            state_d = ST_APPLY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x1_q     <= 1'b0;
      x2_q     <= 1'b0;
      y_q      <= 1'b0;
      step_q   <= '0;
      z_hist_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      y_q      <= y_d;
      step_q   <= step_d;
      z_hist_q <= z_hist_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign x1     = x1_q;
  assign x2     = x2_q;
  assign y      = y_q;
  assign step   = step_q;
  assign z_hist = z_hist_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pass   = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_seq53_run_ctrl.sv
// ============================================================================
// tb_seq53_run_ctrl : randomized scoreboard bench for seq53_run_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq53_run_ctrl;

  localparam int   N      = 8;
  localparam int   DIV    = 2;
  localparam int   STEP_T = DIV + 2;
  localparam int   RUN_T  = N * STEP_T;
  localparam logic INIT_Y = 1'b0;

  // Input pairs {x1,x2} per step, written out as the sequence they encode.
  localparam bit [1:0] PAIRS [N] = '{2'b00, 2'b01, 2'b10, 2'b11,
                                     2'b01, 2'b11, 2'b10, 2'b00};

  typedef struct {
    logic [N-1:0] zh;
    logic [N:0]   ytr;
    int           start_cycle;
  } exp_t;

  logic         cp = 1'b0;
  logic         rst, start, abort;
  logic         ny_a, z_a, x1_a, x2_a, y_a, busy_a, done_a, pass_a;
  logic         ny_b, z_b, x1_b, x2_b, y_b, busy_b, done_b, pass_b;
  logic [3:0]   step_a, step_b;
  logic [N-1:0] zh_a, zh_b;

  int   cycle = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q [$];
  bit   ab_pend = 1'b0;
  int   ab_m    = 0;

  // Behavioural circuit: ny = y ^ x1, z = y & x2.
  assign ny_a = y_a ^ x1_a;
  assign z_a  = y_a & x2_a;
  assign ny_b = y_b ^ x1_b;
  assign z_b  = y_b & x2_b;

  seq53_run_ctrl #(
    .N(N), .DIV(DIV), .PATTERN(16'h2DE4), .INIT_Y(INIT_Y), .EXPECT(8'h08)
  ) dut_a (
    .cp(cp), .rst(rst), .start(start), .abort(abort), .ny_in(ny_a), .z_in(z_a),
    .x1(x1_a), .x2(x2_a), .y(y_a), .step(step_a), .z_hist(zh_a),
    .busy(busy_a), .done(done_a), .pass(pass_a)
  );

  seq53_run_ctrl #(
    .N(N), .DIV(DIV), .PATTERN(16'h2DE4), .INIT_Y(INIT_Y), .EXPECT(8'h00)
  ) dut_b (
    .cp(cp), .rst(rst), .start(start), .abort(abort), .ny_in(ny_b), .z_in(z_b),
    .x1(x1_b), .x2(x2_b), .y(y_b), .step(step_b), .z_hist(zh_b),
    .busy(busy_b), .done(done_b), .pass(pass_b)
  );

  always #5 cp = ~cp;

  always @(posedge cp) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference run: walk the pair list, z = y&x2 then y = y^x1.
  function automatic exp_t model_run(input int k);
    exp_t     e;
    logic     yv;
    bit [1:0] p;
    yv       = INIT_Y;
    e.ytr[0] = yv;
    for (int i = 0; i < N; i++) begin
      p          = PAIRS[i];
      e.zh[i]    = yv & p[0];
      yv         = yv ^ p[1];
      e.ytr[i+1] = yv;
    end
    e.start_cycle = k;
    return e;
  endfunction

  // ------------------------------------------------------------------ monitor
  initial begin : monitor
    logic       busy_p, done_p;
    logic [3:0] step_p;
    exp_t       e;
    logic [7:0] m8;
    int         si;
    busy_p = 1'b0;
    done_p = 1'b0;
    step_p = '0;
    forever begin
      @(posedge cp);
      #1;
      if (rst) begin
        chk("reset_a", {13'd0, x1_a, x2_a, y_a, step_a, zh_a, busy_a, done_a, pass_a}, 32'd0);
        chk("reset_b", {13'd0, x1_b, x2_b, y_b, step_b, zh_b, busy_b, done_b, pass_b}, 32'd0);
      end else begin
        if (busy_a && !busy_p) begin
          chk("start_edge", cycle, (exp_q.size() > 0) ? exp_q[0].start_cycle : -1);
          if (exp_q.size() > 0) begin
            chk("start_y", {31'd0, y_a}, {31'd0, INIT_Y});
            chk("start_zh", {24'd0, zh_a}, 32'd0);
            chk("start_step", {28'd0, step_a}, 32'd0);
            chk("start_clr", {28'd0, done_a, pass_a, done_b, pass_b}, 32'd0);
          end
        end
        if (busy_a && busy_p && step_a != step_p) begin
          chk("step_inc", {28'd0, step_a}, {28'd0, step_p + 4'd1});
          if (exp_q.size() > 0) begin
            si = int'(step_a);
            chk("y_trace", {31'd0, y_a}, {31'd0, exp_q[0].ytr[si]});
            chk("x_hold", {30'd0, x1_a, x2_a}, {30'd0, PAIRS[si-1]});
          end
        end
        if (done_a && !done_p) begin
          if (exp_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cycle - e.start_cycle, RUN_T);
            chk("zh_a", {24'd0, zh_a}, {24'd0, e.zh});
            chk("zh_b", {24'd0, zh_b}, {24'd0, e.zh});
            chk("y_final", {31'd0, y_a}, {31'd0, e.ytr[N]});
            chk("pass_a", {31'd0, pass_a}, {31'd0, e.zh == 8'h08});
            chk("pass_b", {31'd0, pass_b}, {31'd0, e.zh == 8'h00});
            chk("done_not_aborted", {31'd0, ab_pend}, 32'd0);
            chk("x_last", {29'd0, busy_a, x1_a, x2_a}, {30'd0, PAIRS[N-1]});
          end
        end else if (!busy_a && busy_p) begin
          if (exp_q.size() == 0) begin
            chk("abort_unexpected", 32'd1, 32'd0);
          end else begin
            e  = exp_q.pop_front();
            m8 = (8'd1 << ab_m) - 8'd1;
            chk("abort_flag", {31'd0, ab_pend}, 32'd1);
            chk("abort_y", {31'd0, y_a}, {31'd0, e.ytr[ab_m]});
            chk("abort_zh", {24'd0, zh_a}, {24'd0, e.zh & m8});
            chk("abort_outs", {28'd0, x1_a, x2_a, done_a, pass_a}, 32'd0);
            ab_pend = 1'b0;
          end
        end
      end
      busy_p = busy_a;
      done_p = done_a;
      step_p = step_a;
    end
  end

  // ----------------------------------------------------------------- stimulus
  task automatic do_start(output int k);
    @(negedge cp);
    start = 1'b1;
    k     = cycle + 1;
    exp_q.push_back(model_run(k));
    @(negedge cp);
    start = 1'b0;
  endtask

  // Returns at the negedge just before edge e, ready to drive for that edge.
  task automatic wait_edge(input int e);
    while (cycle + 1 < e) @(negedge cp);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2 * RUN_T + 10 && !done_a; i++) @(negedge cp);
    if (!done_a) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_abort(input int k, input int c, input logic with_start);
    wait_edge(k + c);
    ab_pend = 1'b1;
    ab_m    = (c - 1) / STEP_T;
    abort   = 1'b1;
    start   = with_start;
    @(negedge cp);
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin : driver
    int k;
    int j;
    int c;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge cp);
    rst = 1'b0;
    repeat ($urandom_range(3, 8)) @(negedge cp);

    // Plain run from IDLE.
    do_start(k);
    wait_done();

    // Extra start at step 3 must be ignored.
    repeat (2) @(negedge cp);
    do_start(k);
    wait_edge(k + 3 * STEP_T + 2);
    start = 1'b1;
    @(negedge cp);
    start = 1'b0;
    wait_done();

    // Reset held over two SETTLE edges of a random step.
    do_start(k);
    j = $urandom_range(0, N - 1);
    wait_edge(k + j * STEP_T + 2);
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge cp);
    rst = 1'b0;
    repeat (5) @(negedge cp);

    // Abort together with start while applying step 5, then a clean rerun.
    do_start(k);
    do_abort(k, 5 * STEP_T + 1, 1'b1);
    repeat (3) @(negedge cp);
    do_start(k);
    wait_done();

    // Restart directly from DONE.
    repeat (2) @(negedge cp);
    do_start(k);
    wait_done();

    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge cp);
      do_start(k);
      case ($urandom_range(0, 2))
        0: wait_done();
        1: begin
          c = $urandom_range(2, RUN_T);
          wait_edge(k + c);
          start = 1'b1;
          @(negedge cp);
          start = 1'b0;
          wait_done();
        end
        default: begin
          do_abort(k, $urandom_range(1, RUN_T), 1'($urandom_range(0, 1)));
          repeat (2) @(negedge cp);
        end
      endcase
    end

    repeat (4) @(negedge cp);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
